// File: rtl/alu_cmd_driver_if.sv
// Command and response handshake bundle between a host and alu_cmd_driver.
// The host owns the master modport; the driver is the slave.
interface alu_cmd_driver_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_opcode;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands, drives them onto the ALU lines one at a time, waits a
// fixed settle time and returns each captured result in order.
module alu_cmd_driver #(
   parameter int DEPTH       = 4,
   parameter int WAIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_cmd_driver_if.slave  bus,
   output logic [3:0]       alu_opcode_o,
   output logic [7:0]       alu_a_o,
   output logic [7:0]       alu_b_o,
   input  logic [7:0]       alu_out_i,
   output logic             busy_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int WC_W  = $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   logic [19:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   state_t           state_q;
   logic [WC_W-1:0]  wait_q;
   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic [7:0]       rsp_data_q;
   logic [3:0]       alu_opcode_q;
   logic [7:0]       alu_a_q;
   logic [7:0]       alu_b_q;

   logic             full_s;
   logic             push_s;
   logic             pop_s;
   logic [19:0]      head_s;
   logic             head_legal_s;

   assign full_s       = (count_q == CNT_W'(DEPTH));
   assign push_s       = bus.cmd_valid && !full_s;
   assign head_s       = mem_q[rd_ptr_q];
   assign head_legal_s = (head_s[19:16] <= 4'd4);
   // Issue uses the registered count, so a same-edge push is not yet visible.
   assign pop_s        = (count_q != '0) &&
                         ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));

   always_comb begin
      count_d = count_q;
      if (push_s && !pop_s) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_s && pop_s) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 20'd0;
         end
      end else begin
         count_q <= count_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b};
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wait_q       <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= 8'h00;
         alu_opcode_q <= 4'd0;
         alu_a_q      <= 8'h00;
         alu_b_q      <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= IDLE;
            end
            SETTLE: begin
               if (wait_q > WC_W'(1)) begin
                  wait_q <= wait_q - WC_W'(1);
               end else begin
                  rsp_data_q  <= alu_out_i;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         // An issue overrides the per-state update above; the RESP handshake edge doubles as issue.
         if (pop_s) begin
            if (head_legal_s) begin
               alu_opcode_q <= head_s[19:16];
               alu_a_q      <= head_s[15:8];
               alu_b_q      <= head_s[7:0];
               wait_q       <= WC_W'(WAIT_CYCLES);
               state_q      <= SETTLE;
            end else begin
               rsp_data_q  <= 8'h00;
               rsp_err_q   <= 1'b1;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
         end
      end
   end

   assign bus.cmd_ready = !full_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign alu_opcode_o  = alu_opcode_q;
   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign busy_o        = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Drives two driver instances (settle 1 and 3) with shared stimulus and checks
// each against a transaction-level model of accept, issue and response timing.
module tb_alu_cmd_driver;
   localparam int DEPTH = 4;

   typedef struct packed {
      int         acc;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic [3:0] cmd_opcode;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       rsp_ready;

   int n_vec = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return ~a;
         default: return 8'h00;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int W = (g == 0) ? 1 : 3;

      alu_cmd_driver_if u_if ();
      logic [3:0] alu_op;
      logic [7:0] alu_a;
      logic [7:0] alu_b;
      logic [7:0] alu_out;
      logic       busy;

      assign u_if.cmd_valid  = cmd_valid;
      assign u_if.cmd_opcode = cmd_opcode;
      assign u_if.cmd_a      = cmd_a;
      assign u_if.cmd_b      = cmd_b;
      assign u_if.rsp_ready  = rsp_ready;

      alu_cmd_driver #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .bus          (u_if),
         .alu_opcode_o (alu_op),
         .alu_a_o      (alu_a),
         .alu_b_o      (alu_b),
         .alu_out_i    (alu_out),
         .busy_o       (busy)
      );

      // ALU stand-in: output is garbage until its inputs have been stable for W-1 edges.
      logic [19:0] alu_seen = 20'd0;
      int          settle_k = 1000;
      always @(negedge clk) begin
         if ({alu_op, alu_a, alu_b} != alu_seen) begin
            alu_seen = {alu_op, alu_a, alu_b};
            settle_k = 0;
         end else if (settle_k < 1000) begin
            settle_k++;
         end
      end
      assign alu_out = (settle_k >= W - 1) ? alu_ref(alu_op, alu_a, alu_b)
                                           : ~alu_ref(alu_op, alu_a, alu_b);

      cmd_t       q[$];
      cmd_t       h;
      int         n_edge    = 0;
      int         last_hs   = -1000;
      int         iss;
      int         issued;
      int         q_len     = 0;
      logic       exp_valid = 1'b0;
      logic       exp_ready = 1'b0;
      logic       exp_err;
      logic       legal;
      logic       just_rst;
      logic [7:0] exp_data;
      logic [3:0] e_op = 4'd0;
      logic [7:0] e_a  = 8'h00;
      logic [7:0] e_b  = 8'h00;

      always @(negedge clk) begin
         n_edge++;
         just_rst = !rst_n;
         if (!rst_n) begin
            q.delete();
            last_hs = -1000;
            e_op    = 4'd0;
            e_a     = 8'h00;
            e_b     = 8'h00;
         end else begin
            if (exp_valid && rsp_ready) begin
               void'(q.pop_front());
               last_hs = n_edge;
            end
            if (cmd_valid && exp_ready) begin
               q.push_back('{n_edge, cmd_opcode, cmd_a, cmd_b});
            end
         end
         exp_valid = 1'b0;
         exp_data  = 8'h00;
         exp_err   = 1'b0;
         issued    = 0;
         if (q.size() > 0) begin
            h      = q[0];
            iss    = (h.acc < last_hs) ? last_hs : h.acc + 1;
            legal  = (h.op <= 4'd4);
            issued = (n_edge >= iss) ? 1 : 0;
            if ((issued != 0) && legal) begin
               e_op = h.op;
               e_a  = h.a;
               e_b  = h.b;
            end
            exp_valid = (n_edge >= iss + (legal ? W : 0));
            exp_data  = legal ? alu_ref(h.op, h.a, h.b) : 8'h00;
            exp_err   = !legal;
         end
         exp_ready = ((q.size() - issued) < DEPTH);
         q_len     = q.size();

         check_eq($sformatf("w%0d_rsp_valid", W), 32'(u_if.rsp_valid), 32'(exp_valid));
         check_eq($sformatf("w%0d_cmd_ready", W), 32'(u_if.cmd_ready), 32'(exp_ready));
         check_eq($sformatf("w%0d_busy", W), 32'(busy), 32'(q.size() != 0));
         check_eq($sformatf("w%0d_alu_opcode", W), 32'(alu_op), 32'(e_op));
         check_eq($sformatf("w%0d_alu_a", W), 32'(alu_a), 32'(e_a));
         check_eq($sformatf("w%0d_alu_b", W), 32'(alu_b), 32'(e_b));
         if (exp_valid || just_rst) begin
            check_eq($sformatf("w%0d_rsp_data", W), 32'(u_if.rsp_data), 32'(exp_data));
            check_eq($sformatf("w%0d_rsp_err", W), 32'(u_if.rsp_err), 32'(exp_err));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int guard = 0;
      while (!(g_inst[0].exp_ready && g_inst[1].exp_ready) && guard < 200) begin
         tick();
         guard++;
      end
      check_eq("push_wait_bounded", 32'(guard >= 200), 32'd0);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      tick();
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((g_inst[0].q_len != 0 || g_inst[1].q_len != 0) && guard < 500) begin
         tick();
         guard++;
      end
      check_eq("drain_bounded", 32'(guard >= 500), 32'd0);
      repeat (2) tick();
   endtask

   initial begin
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_opcode = 4'd0;
      cmd_a      = 8'h00;
      cmd_b      = 8'h00;
      rsp_ready  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      rsp_ready = 1'b1;
      push(4'd0, 8'h12, 8'h34);
      push(4'd1, 8'h10, 8'h20);
      push(4'd4, 8'h55, 8'h00);
      wait_idle();

      rsp_ready = 1'b0;
      push(4'd0, 8'h12, 8'h34);
      push(4'd2, 8'hF0, 8'h3C);
      push(4'd3, 8'hF0, 8'h0F);
      push(4'd1, 8'h05, 8'h01);
      push(4'd4, 8'h00, 8'h00);
      repeat (10) tick();
      rsp_ready = 1'b1;
      wait_idle();

      push(4'd3, 8'h21, 8'h42);
      push(4'd9, 8'hAA, 8'hBB);
      push(4'd0, 8'h01, 8'h02);
      wait_idle();

      push(4'd0, 8'hFF, 8'h01);
      wait_idle();

      push(4'd0, 8'h11, 8'h22);
      push(4'd1, 8'h33, 8'h44);
      push(4'd2, 8'h55, 8'h66);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (20) tick();

      for (int i = 0; i < 800; i++) begin
         int r;
         r          = $urandom_range(0, 9);
         cmd_valid  = $urandom_range(0, 1) == 1;
         cmd_opcode = (r < 8) ? 4'(r % 5) : 4'($urandom_range(5, 15));
         cmd_a      = 8'($urandom);
         cmd_b      = 8'($urandom);
         rsp_ready  = $urandom_range(0, 3) != 0;
         rst_n      = (i != 400);
         tick();
      end
      cmd_valid = 1'b0;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side driver for the team's 8-bit ALU. It accepts packed ALU commands (opcode, a, b) over a valid/ready handshake and queues them in a small FIFO. It drives each command onto the ALU operand/opcode lines, waits a programmable settle time, then captures the ALU result and returns it in order over a second valid/ready handshake. It sits between any sequencer or test host and the ALU, and is the only block that drives the ALU's inputs.

## Interface
- DEPTH, 4, command FIFO entries; power of two, minimum 2
- WAIT_CYCLES, 1, clock edges between driving alu_* and sampling alu_out; minimum 1
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept (= not full)
- cmd_opcode  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT; 5..15 illegal
- cmd_a  input  8  operand a
- cmd_b  input  8  operand b
- alu_opcode  output  4  registered opcode to ALU
- alu_a  output  8  registered operand a to ALU
- alu_b  output  8  registered operand b to ALU
- alu_out  input  8  ALU result; combinational from alu_*, stable within WAIT_CYCLES
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  8  captured result
- rsp_err  output  1  command had illegal opcode
- busy  output  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO: 20-bit entries {opcode, a, b}, DEPTH deep, in-order.
  - Push on cmd_valid && cmd_ready.
  - Pop on command issue.
  - Push and pop on the same edge leave the count unchanged.
  - Pointers wrap modulo DEPTH. Count is 0..DEPTH; full when count == DEPTH.
- cmd_ready = !full (combinational from the registered count). cmd_* is ignored when cmd_ready = 0.
- FSM states: IDLE, SETTLE, RESP.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, head legal: pop, load alu_opcode/alu_a/alu_b from head, set cnt = WAIT_CYCLES, go to SETTLE.
  - IDLE, head illegal: pop, leave alu_* unchanged, rsp_data = 0x00, rsp_err = 1, rsp_valid = 1, go to RESP.
  - SETTLE, cnt > 1: decrement cnt.
  - SETTLE, cnt == 1: rsp_data = alu_out, rsp_err = 0, rsp_valid = 1, go to RESP.
  - RESP, !rsp_ready: hold everything.
  - RESP, rsp_ready: clear rsp_valid. If the FIFO is non-empty (count before any same-edge push), issue the head exactly as IDLE would (legal → SETTLE, illegal → RESP again with the error response). Otherwise go to IDLE.
- alu_* hold their last issued values between commands and during illegal-opcode responses.
- Arithmetic is the ALU's job. The driver passes alu_out through unmodified; 8-bit wrap comes from the ALU.
- busy = (state != IDLE) || (count != 0).

## Timing
- Reset: when rst_n = 0 at an edge, every register clears on that edge.
  - State IDLE, FIFO empty, pointers 0, cnt 0.
  - alu_opcode = 0, alu_a = 0, alu_b = 0, rsp_valid = 0, rsp_data = 0x00, rsp_err = 0, busy = 0.
  - cmd_ready = 1 after the reset edge. Pushes presented while rst_n = 0 are dropped.
  - Mid-operation reset: in-flight and queued commands are discarded with no response.
- Latency, legal command into an idle block:
  - Accepted at edge E0, issued at E1, captured at E(1 + WAIT_CYCLES).
  - rsp_valid is high from then on, i.e. WAIT_CYCLES + 1 edges after acceptance.
- Latency, illegal command: rsp_valid high after E1.
- Throughput with rsp_ready held high: one legal response every WAIT_CYCLES + 1 cycles (the RESP handshake edge doubles as the next issue edge).
- Backpressure: while rsp_valid && !rsp_ready, rsp_data, rsp_err, alu_* and the FSM are frozen; the FIFO keeps accepting until full.
- Same-edge push into an empty FIFO and an IDLE check: the new entry is not visible until the next edge.

## Test plan
- Reset, WAIT_CYCLES = 1, push ADD a=0x12 b=0x34 at E0 -> alu_* = {0, 0x12, 0x34} after E1; rsp_valid after E2; rsp_data = 0x46, rsp_err = 0.
- SUB a=0x10 b=0x20 -> rsp_data = 0xF0. NOT a=0x55 -> 0xAA.
- DEPTH = 4, rsp_ready held low, push ADD, AND(0xF0, 0x3C), OR(0xF0, 0x0F), SUB(0x05, 0x01), NOT(0x00) ->
  - cmd_ready drops after the fifth accept (four queued, one in RESP).
  - Responses are held stable while rsp_ready is low.
  - After rsp_ready = 1, responses arrive in order: ADD, 0x30, 0xFF, 0x04, 0xFF, each spaced 2 cycles apart.
- cmd_opcode = 9 after a legal OR -> rsp_err = 1, rsp_data = 0x00, alu_opcode still 3, latency 1 edge; the next legal command issues normally.
- WAIT_CYCLES = 3, ADD 0xFF + 0x01 -> capture at E4, rsp_data = 0x00; the ALU model changing alu_out at E2 must not be sampled.
- rst_n low for one edge while in SETTLE with 2 queued -> all outputs at reset values after that edge; busy = 0; no responses ever appear for the discarded commands.
